// File: rtl/msg_seq_pkg.sv
// Shared symbol codes, state encoding and default message for the message sequencer.
package msg_seq_pkg;

  localparam int unsigned BLANK = 0;
  localparam int unsigned H     = 1;
  localparam int unsigned E     = 2;
  localparam int unsigned L     = 3;
  localparam int unsigned O     = 4;

  localparam int unsigned DEFAULT_LEN = 5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SHOW = 2'd1,
    S_GAP  = 2'd2
  } state_e;

  // Default message "HELLO"; entries past the end read as BLANK.
  function automatic int unsigned default_sym(input int unsigned idx);
    int unsigned sym;
    case (idx)
      0:       sym = H;
      1:       sym = E;
      2:       sym = L;
      3:       sym = L;
      4:       sym = O;
      default: sym = BLANK;
    endcase
    return sym;
  endfunction

endpackage

// File: rtl/msg_sequencer_if.sv
// Control/status bundle of the message sequencer. Digits exists only when MSG_SCROLL_EN is defined.
interface msg_sequencer_if #(
  parameter int unsigned SYM_W      = 3,
  parameter int unsigned MSG_LEN    = 5,
  parameter int unsigned NUM_DIGITS = 4
);
  localparam int unsigned AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;

  logic             Start;
  logic             Abort;
  logic             Loop;
  logic             Hold;
  logic             Tick;
  logic             WrEn;
  logic [AW-1:0]    WrAddr;
  logic [SYM_W-1:0] WrData;
  logic [SYM_W-1:0] Out;
  logic             Valid;
  logic             Busy;
  logic             Done;
  logic [AW-1:0]    Index;
`ifdef MSG_SCROLL_EN
  logic [NUM_DIGITS*SYM_W-1:0] Digits;
`endif

  modport master (
    output Start, Abort, Loop, Hold, Tick, WrEn, WrAddr, WrData,
`ifdef MSG_SCROLL_EN
    input  Digits,
`endif
    input  Out, Valid, Busy, Done, Index
  );

  modport slave (
    input  Start, Abort, Loop, Hold, Tick, WrEn, WrAddr, WrData,
`ifdef MSG_SCROLL_EN
    output Digits,
`endif
    output Out, Valid, Busy, Done, Index
  );

endinterface

// File: rtl/msg_store.sv
// Runtime-writable message register file: sync reset to the default message, one write, one comb read.
module msg_store
  import msg_seq_pkg::*;
#(
  parameter int unsigned SYM_W   = 3,
  parameter int unsigned MSG_LEN = 5,
  parameter int unsigned AW      = 3
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [SYM_W-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [SYM_W-1:0] rd_data
);

  logic [SYM_W-1:0] mem [MSG_LEN];

  // Out-of-range write addresses are dropped rather than aliased.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      for (int i = 0; i < int'(MSG_LEN); i++) begin
        mem[i] <= SYM_W'(default_sym(32'(i)));
      end
    end else if (wr_en && (32'(wr_addr) < MSG_LEN)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/msg_sequencer.sv
// Message sequencer FSM: plays the stored symbol string then a blank gap, once or looping.
// Optional scroll window register enabled by defining MSG_SCROLL_EN.
module msg_sequencer
  import msg_seq_pkg::*;
#(
  parameter int unsigned SYM_W      = 3,
  parameter int unsigned MSG_LEN    = 5,
  parameter int unsigned GAP_LEN    = 3,
  parameter int unsigned NUM_DIGITS = 4
) (
  input  logic           Clock,
  input  logic           Reset,
  msg_sequencer_if.slave bus
);

  localparam int unsigned IW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1;
  localparam int unsigned GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

  localparam logic [1:0] IDLE = S_IDLE;
  localparam logic [1:0] SHOW = S_SHOW;
  localparam logic [1:0] GAP  = S_GAP;

  localparam logic [IW-1:0]    LAST_IDX  = IW'(MSG_LEN - 1);
  localparam logic [GW-1:0]    LAST_GAP  = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
  localparam logic [SYM_W-1:0] BLANK_SYM = SYM_W'(BLANK);

  logic [1:0]       state, state_n;
  logic [SYM_W-1:0] out_q, out_n;
  logic [IW-1:0]    index_q, index_n;
  logic [GW-1:0]    gap_q, gap_n;
  logic             valid_q, busy_q, done_q, done_n;
  logic             load_c, eof_c, adv_c;
  logic [IW-1:0]    rd_addr_c;
  logic [SYM_W-1:0] rd_data;

  msg_store #(
    .SYM_W   (SYM_W),
    .MSG_LEN (MSG_LEN),
    .AW      (IW)
  ) u_store (
    .Clock   (Clock),
    .Reset   (Reset),
    .wr_en   (bus.WrEn),
    .wr_addr (bus.WrAddr),
    .wr_data (bus.WrData),
    .rd_addr (rd_addr_c),
    .rd_data (rd_data)
  );

  assign adv_c = bus.Tick && !bus.Hold;

  always_ff @(posedge Clock) begin
    if (!Reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and next output values; Abort is applied last so it overrides everything.
  always_comb begin
    state_n   = state;
    out_n     = out_q;
    index_n   = index_q;
    gap_n     = gap_q;
    done_n    = 1'b0;
    load_c    = 1'b0;
    eof_c     = 1'b0;
    rd_addr_c = '0;

    case (state)
      IDLE: begin
        if (bus.Start) begin
          state_n = SHOW;
          index_n = '0;
          out_n   = rd_data;
          load_c  = 1'b1;
        end
      end
      SHOW: begin
        if (adv_c) begin
          if (index_q < LAST_IDX) begin
            index_n   = index_q + 1'b1;
            rd_addr_c = index_q + 1'b1;
            out_n     = rd_data;
            load_c    = 1'b1;
          end else if (GAP_LEN > 0) begin
            state_n = GAP;
            gap_n   = '0;
            out_n   = BLANK_SYM;
            load_c  = 1'b1;
          end else begin
            eof_c = 1'b1;
          end
        end
      end
      GAP: begin
        if (adv_c) begin
          if (gap_q >= LAST_GAP) eof_c = 1'b1;
          else                   gap_n = gap_q + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (eof_c) begin
      done_n    = 1'b1;
      gap_n     = '0;
      index_n   = '0;
      rd_addr_c = '0;
      load_c    = 1'b1;
      if (bus.Loop) begin
        state_n = SHOW;
        out_n   = rd_data;
      end else begin
        state_n = IDLE;
        out_n   = BLANK_SYM;
      end
    end

    if (bus.Abort) begin
      state_n = IDLE;
      out_n   = BLANK_SYM;
      index_n = '0;
      gap_n   = '0;
      done_n  = 1'b0;
      load_c  = 1'b0;
    end
  end

  // Status flags are registered alongside the state so they line up with it.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      out_q   <= BLANK_SYM;
      index_q <= '0;
      gap_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      out_q   <= out_n;
      index_q <= index_n;
      gap_q   <= gap_n;
      valid_q <= (state_n == SHOW);
      busy_q  <= (state_n != IDLE);
      done_q  <= done_n;
    end
  end

  assign bus.Out   = out_q;
  assign bus.Index = index_q;
  assign bus.Valid = valid_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;

`ifdef MSG_SCROLL_EN
  localparam int unsigned DW = NUM_DIGITS * SYM_W;

  logic [DW-1:0] digits_q;

  // Newest symbol enters the low slot whenever Out is reloaded.
  always_ff @(posedge Clock) begin
    if (!Reset || bus.Abort) digits_q <= '0;
    else if (load_c)         digits_q <= (digits_q << SYM_W) | DW'(out_n);
  end

  assign bus.Digits = digits_q;
`endif

endmodule

// File: tb/tb_msg_sequencer.sv
// Directed self-checking bench for msg_sequencer (default parameters: HELLO, 3-symbol gap).
module tb_msg_sequencer;

  logic Clock;
  logic Reset;
  int   n_checks;
  int   n_fail;

  msg_sequencer_if #(.SYM_W(3), .MSG_LEN(5), .NUM_DIGITS(4)) bus ();

  msg_sequencer #(
    .SYM_W      (3),
    .MSG_LEN    (5),
    .GAP_LEN    (3),
    .NUM_DIGITS (4)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic cycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic tick_cycle();
    bus.Tick = 1'b1;
    cycle();
    bus.Tick = 1'b0;
  endtask

  task automatic start_cycle();
    bus.Start = 1'b1;
    cycle();
    bus.Start = 1'b0;
  endtask

  task automatic abort_cycle();
    bus.Abort = 1'b1;
    cycle();
    bus.Abort = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    cycle();
    cycle();
    Reset = 1'b1;
    n_checks++; if (bus.Out !== 3'd0) begin n_fail++; $display("FAIL reset_out: got %0d exp 0", bus.Out); end
    n_checks++; if (bus.Valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b exp 0", bus.Valid); end
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b exp 0", bus.Busy); end
    n_checks++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b exp 0", bus.Done); end
    n_checks++; if (bus.Index !== 3'd0) begin n_fail++; $display("FAIL reset_index: got %0d exp 0", bus.Index); end
    // Tick in IDLE must not start anything
    tick_cycle();
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL idle_tick_busy: got %0b exp 0", bus.Busy); end
  endtask

  task automatic test_single_frame();
    int exp_out [8];
    exp_out = '{1, 2, 3, 3, 4, 0, 0, 0};
    bus.Loop = 1'b0;
    start_cycle();
    n_checks++; if (bus.Out !== 3'(exp_out[0])) begin n_fail++; $display("FAIL single_start_out: got %0d exp %0d", bus.Out, exp_out[0]); end
    n_checks++; if (bus.Valid !== 1'b1) begin n_fail++; $display("FAIL single_start_valid: got %0b exp 1", bus.Valid); end
    n_checks++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL single_start_busy: got %0b exp 1", bus.Busy); end
`ifdef MSG_SCROLL_EN
    n_checks++; if (bus.Digits !== 12'h001) begin n_fail++; $display("FAIL single_start_digits: got %h exp 001", bus.Digits); end
`endif
    for (int t = 1; t <= 8; t++) begin
      tick_cycle();
      if (t < 8) begin
        n_checks++; if (bus.Out !== 3'(exp_out[t])) begin n_fail++; $display("FAIL single_out t=%0d: got %0d exp %0d", t, bus.Out, exp_out[t]); end
        n_checks++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL single_done t=%0d: got %0b exp 0", t, bus.Done); end
        n_checks++; if (bus.Valid !== (t < 5)) begin n_fail++; $display("FAIL single_valid t=%0d: got %0b exp %0b", t, bus.Valid, (t < 5)); end
        if (t <= 4) begin
          n_checks++; if (bus.Index !== 3'(t)) begin n_fail++; $display("FAIL single_index t=%0d: got %0d exp %0d", t, bus.Index, t); end
        end
      end else begin
        n_checks++; if (bus.Done !== 1'b1) begin n_fail++; $display("FAIL single_eof_done: got %0b exp 1", bus.Done); end
        n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL single_eof_busy: got %0b exp 0", bus.Busy); end
        n_checks++; if (bus.Out !== 3'd0) begin n_fail++; $display("FAIL single_eof_out: got %0d exp 0", bus.Out); end
      end
    end
    cycle();
    n_checks++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL single_done_pulse: got %0b exp 0", bus.Done); end
  endtask

  task automatic test_loop();
    int exp_out [8];
    int p;
    exp_out = '{1, 2, 3, 3, 4, 0, 0, 0};
    bus.Loop = 1'b1;
    start_cycle();
    for (int t = 1; t <= 16; t++) begin
      p = t % 8;
      if (t == 3) bus.Start = 1'b1;
      tick_cycle();
      bus.Start = 1'b0;
      n_checks++; if (bus.Out !== 3'(exp_out[p])) begin n_fail++; $display("FAIL loop_out t=%0d: got %0d exp %0d", t, bus.Out, exp_out[p]); end
      n_checks++; if (bus.Done !== (p == 0)) begin n_fail++; $display("FAIL loop_done t=%0d: got %0b exp %0b", t, bus.Done, (p == 0)); end
      n_checks++; if (bus.Valid !== (p < 5)) begin n_fail++; $display("FAIL loop_valid t=%0d: got %0b exp %0b", t, bus.Valid, (p < 5)); end
      n_checks++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL loop_busy t=%0d: got %0b exp 1", t, bus.Busy); end
    end
    abort_cycle();
    bus.Loop = 1'b0;
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL loop_abort_busy: got %0b exp 0", bus.Busy); end
  endtask

  task automatic test_hold_and_abort();
    start_cycle();
    tick_cycle();
    tick_cycle();
    n_checks++; if (bus.Index !== 3'd2) begin n_fail++; $display("FAIL hold_pre_index: got %0d exp 2", bus.Index); end
    bus.Hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick_cycle();
      n_checks++; if (bus.Out !== 3'd3) begin n_fail++; $display("FAIL hold_out k=%0d: got %0d exp 3", k, bus.Out); end
      n_checks++; if (bus.Index !== 3'd2) begin n_fail++; $display("FAIL hold_index k=%0d: got %0d exp 2", k, bus.Index); end
    end
    bus.Hold = 1'b0;
    cycle();
    n_checks++; if (bus.Index !== 3'd2) begin n_fail++; $display("FAIL hold_not_queued: got %0d exp 2", bus.Index); end
    tick_cycle();
    n_checks++; if (bus.Index !== 3'd3) begin n_fail++; $display("FAIL hold_release_index: got %0d exp 3", bus.Index); end
    // Abort together with Tick at Index 3
    bus.Tick  = 1'b1;
    bus.Abort = 1'b1;
    cycle();
    bus.Tick  = 1'b0;
    bus.Abort = 1'b0;
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b exp 0", bus.Busy); end
    n_checks++; if (bus.Out !== 3'd0) begin n_fail++; $display("FAIL abort_out: got %0d exp 0", bus.Out); end
    n_checks++; if (bus.Index !== 3'd0) begin n_fail++; $display("FAIL abort_index: got %0d exp 0", bus.Index); end
    n_checks++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL abort_done: got %0b exp 0", bus.Done); end
    bus.Start = 1'b1;
    bus.Abort = 1'b1;
    cycle();
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL abort_start_busy: got %0b exp 0", bus.Busy); end
    n_checks++; if (bus.Out !== 3'd0) begin n_fail++; $display("FAIL abort_start_out: got %0d exp 0", bus.Out); end
  endtask

  task automatic test_write();
    int exp_out [5];
    exp_out = '{1, 4, 3, 3, 4};
    bus.Loop = 1'b0;
    start_cycle();
    tick_cycle();
    bus.WrEn   = 1'b1;
    bus.WrAddr = 3'd1;
    bus.WrData = 3'd4;
    cycle();
    bus.WrAddr = 3'd7;
    bus.WrData = 3'd7;
    cycle();
    bus.WrEn = 1'b0;
    n_checks++; if (bus.Out !== 3'd2) begin n_fail++; $display("FAIL write_shown_out: got %0d exp 2", bus.Out); end
    for (int t = 0; t < 7; t++) tick_cycle();
    n_checks++; if (bus.Done !== 1'b1) begin n_fail++; $display("FAIL write_frame_done: got %0b exp 1", bus.Done); end
    start_cycle();
    for (int t = 0; t < 5; t++) begin
      n_checks++; if (bus.Out !== 3'(exp_out[t])) begin n_fail++; $display("FAIL write_frame_out i=%0d: got %0d exp %0d", t, bus.Out, exp_out[t]); end
      tick_cycle();
    end
    abort_cycle();
    // Write and load of entry 0 in the same cycle returns the old symbol
    bus.WrEn   = 1'b1;
    bus.WrAddr = 3'd0;
    bus.WrData = 3'd4;
    start_cycle();
    bus.WrEn = 1'b0;
    n_checks++; if (bus.Out !== 3'd1) begin n_fail++; $display("FAIL write_collide_out: got %0d exp 1", bus.Out); end
    abort_cycle();
    start_cycle();
    n_checks++; if (bus.Out !== 3'd4) begin n_fail++; $display("FAIL write_new_entry0: got %0d exp 4", bus.Out); end
    abort_cycle();
  endtask

  task automatic test_reset_in_gap();
    start_cycle();
    for (int t = 0; t < 6; t++) tick_cycle();
    n_checks++; if (bus.Valid !== 1'b0) begin n_fail++; $display("FAIL gap_valid: got %0b exp 0", bus.Valid); end
    n_checks++; if (bus.Busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy: got %0b exp 1", bus.Busy); end
    Reset    = 1'b0;
    bus.Tick = 1'b1;
    cycle();
    bus.Tick = 1'b0;
    Reset    = 1'b1;
    n_checks++; if (bus.Busy !== 1'b0) begin n_fail++; $display("FAIL gap_reset_busy: got %0b exp 0", bus.Busy); end
    n_checks++; if (bus.Out !== 3'd0) begin n_fail++; $display("FAIL gap_reset_out: got %0d exp 0", bus.Out); end
    n_checks++; if (bus.Done !== 1'b0) begin n_fail++; $display("FAIL gap_reset_done: got %0b exp 0", bus.Done); end
`ifdef MSG_SCROLL_EN
    n_checks++; if (bus.Digits !== 12'h000) begin n_fail++; $display("FAIL gap_reset_digits: got %h exp 000", bus.Digits); end
`endif
    start_cycle();
    n_checks++; if (bus.Out !== 3'd1) begin n_fail++; $display("FAIL gap_reset_store0: got %0d exp 1", bus.Out); end
    tick_cycle();
    n_checks++; if (bus.Out !== 3'd2) begin n_fail++; $display("FAIL gap_reset_store1: got %0d exp 2", bus.Out); end
    abort_cycle();
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    Reset      = 1'b0;
    bus.Start  = 1'b0;
    bus.Abort  = 1'b0;
    bus.Loop   = 1'b0;
    bus.Hold   = 1'b0;
    bus.Tick   = 1'b0;
    bus.WrEn   = 1'b0;
    bus.WrAddr = '0;
    bus.WrData = '0;
    test_reset();
    test_single_frame();
    test_loop();
    test_hold_and_abort();
    test_write();
    test_reset_in_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
